// File: rtl/key_filter_n.sv
// key_filter_n -- button/switch conditioner between board pins and the
// calculator control logic.
//
// Each pin goes through a 2-flop synchroniser and a consecutive-sample
// debounce filter. The filter is clocked by an internal sample tick, so
// everything runs on clk. Buttons also get press/release/long-press and
// auto-repeat pulses. Switches get a change pulse.
//
// Ports
//   clk          system clock (only clock)
//   rst_n        synchronous active-low reset
//   repeat_en    enables btn_repeat generation
//   btn_in       raw button pins, active-high        [NBTN]
//   sw_in        raw switch pins, active-high        [NSW]
//   btn_level    debounced button level              [NBTN]
//   btn_press    1-clk pulse, debounced rising edge  [NBTN]
//   btn_release  1-clk pulse, debounced falling edge [NBTN]
//   btn_long     1-clk pulse when hold reaches HOLD_TICKS
//   btn_repeat   1-clk auto-repeat pulse train
//   sw_level     debounced switch level              [NSW]
//   sw_change    1-clk pulse on any debounced switch transition
//
// REPEAT_TICKS is expected to be <= HOLD_TICKS; the repeat reload point
// sits REPEAT_TICKS below the long-press count.
module key_filter_n #(
  parameter int NBTN         = 5,
  parameter int NSW          = 8,
  parameter int TICK_DIV     = 500000,
  parameter int DEPTH        = 3,
  parameter int HOLD_TICKS   = 100,
  parameter int REPEAT_TICKS = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            repeat_en,
  input  logic [NBTN-1:0] btn_in,
  input  logic [NSW-1:0]  sw_in,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_press,
  output logic [NBTN-1:0] btn_release,
  output logic [NBTN-1:0] btn_long,
  output logic [NBTN-1:0] btn_repeat,
  output logic [NSW-1:0]  sw_level,
  output logic [NSW-1:0]  sw_change
);

  // Buttons occupy the low NBTN channels, switches the upper NSW.
  localparam int NCH = NBTN + NSW;
  localparam int PW  = $clog2(TICK_DIV + 1);
  localparam int CW  = $clog2(DEPTH);
  localparam int HW  = $clog2(HOLD_TICKS + REPEAT_TICKS + 1);

  localparam logic [PW-1:0] DIV_LAST    = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST    = CW'(DEPTH - 1);
  localparam logic [HW-1:0] HOLD_TOP    = HW'(HOLD_TICKS);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_TICKS - REPEAT_TICKS);

  logic [NCH-1:0]  sync1_q, sync2_q;
  logic [NCH-1:0]  level_q, level_d;
  logic [NCH-1:0]  rise_q, rise_d;
  logic [NCH-1:0]  fall_q, fall_d;
  logic [NCH-1:0]  toggle;
  logic [CW-1:0]   flt_cnt_q [NCH];
  logic [CW-1:0]   flt_cnt_d [NCH];
  logic [PW-1:0]   div_q, div_d;
  logic            tick;

  logic [HW-1:0]   hold_q    [NBTN];
  logic [HW-1:0]   hold_d    [NBTN];
  logic [HW-1:0]   hold_inc  [NBTN];
  logic [HW-1:0]   rep_inc   [NBTN];
  logic [NBTN-1:0] done_q, done_d;
  logic [NBTN-1:0] long_q, long_d;
  logic [NBTN-1:0] rep_q, rep_d;

  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + 1'b1;

    toggle = '0;
    for (int i = 0; i < NCH; i++) begin
      flt_cnt_d[i] = flt_cnt_q[i];
      toggle[i]    = tick && (sync2_q[i] != level_q[i]) && (flt_cnt_q[i] == CNT_LAST);
      if (tick) begin
        // Any agreeing sample restarts the run of disagreeing samples.
        if ((sync2_q[i] == level_q[i]) || toggle[i])
          flt_cnt_d[i] = '0;
        else
          flt_cnt_d[i] = flt_cnt_q[i] + 1'b1;
      end
    end
    level_d = level_q ^ toggle;
    rise_d  = toggle & ~level_q;
    fall_d  = toggle & level_q;

    done_d = done_q;
    long_d = '0;
    rep_d  = '0;
    for (int j = 0; j < NBTN; j++) begin
      hold_d[j]   = hold_q[j];
      hold_inc[j] = hold_q[j] + 1'b1;
      // Sitting at the top means repeat was off; re-enabling restarts a period.
      rep_inc[j]  = ((hold_q[j] == HOLD_TOP) ? HOLD_RELOAD : hold_q[j]) + 1'b1;
      if (rise_d[j]) begin
        hold_d[j] = '0;
        done_d[j] = 1'b0;
        rep_d[j]  = repeat_en;
      end else if (fall_d[j]) begin
        hold_d[j] = '0;
        done_d[j] = 1'b0;
      end else if (tick && level_q[j]) begin
        if (!done_q[j]) begin
          hold_d[j] = hold_inc[j];
          if (hold_inc[j] == HOLD_TOP) begin
            long_d[j] = 1'b1;
            done_d[j] = 1'b1;
            rep_d[j]  = repeat_en;
            if (repeat_en)
              hold_d[j] = HOLD_RELOAD;
          end
        end else if (repeat_en) begin
          if (rep_inc[j] == HOLD_TOP) begin
            rep_d[j]  = 1'b1;
            hold_d[j] = HOLD_RELOAD;
          end else begin
            hold_d[j] = rep_inc[j];
          end
        end else begin
          hold_d[j] = (hold_q[j] == HOLD_TOP) ? HOLD_TOP : hold_inc[j];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      div_q     <= '0;
      flt_cnt_q <= '{default: '0};
      hold_q    <= '{default: '0};
      done_q    <= '0;
      long_q    <= '0;
      rep_q     <= '0;
    end else begin
      sync1_q   <= {sw_in, btn_in};
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      div_q     <= div_d;
      flt_cnt_q <= flt_cnt_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      long_q    <= long_d;
      rep_q     <= rep_d;
    end
  end

  assign btn_level   = level_q[NBTN-1:0];
  assign btn_press   = rise_q[NBTN-1:0];
  assign btn_release = fall_q[NBTN-1:0];
  assign btn_long    = long_q;
  assign btn_repeat  = rep_q;
  assign sw_level    = level_q[NCH-1:NBTN];
  assign sw_change   = rise_q[NCH-1:NBTN] | fall_q[NCH-1:NBTN];

endmodule

// File: tb/tb_key_filter_n.sv
module tb_key_filter_n;

  localparam int NBTN = 5;
  localparam int NSW  = 8;
  localparam int TDIV = 4;
  localparam int DEP  = 3;
  localparam int HOLD = 8;
  localparam int REP  = 3;
  localparam int NCH  = NBTN + NSW;

  logic            clk;
  logic            rst_n;
  logic            repeat_en;
  logic [NBTN-1:0] btn_in;
  logic [NSW-1:0]  sw_in;
  logic [NBTN-1:0] btn_level, btn_press, btn_release, btn_long, btn_repeat;
  logic [NSW-1:0]  sw_level, sw_change;

  key_filter_n #(
    .NBTN(NBTN), .NSW(NSW), .TICK_DIV(TDIV), .DEPTH(DEP),
    .HOLD_TICKS(HOLD), .REPEAT_TICKS(REP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .repeat_en(repeat_en),
    .btn_in(btn_in), .sw_in(sw_in),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_long(btn_long), .btn_repeat(btn_repeat),
    .sw_level(sw_level), .sw_change(sw_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pins seen two clocks late, one sample per TDIV clocks,
  // a level flips once its last DEP samples all disagree with it. Hold
  // behaviour is tracked as ticks since press and ticks since last repeat.
  logic [NCH-1:0]  m_s1, m_s2, m_lvl, m_rise, m_fall, m_raw, m_smp;
  logic [DEP-1:0]  m_hist [NCH];
  logic [NBTN-1:0] m_long, m_rep;
  int              m_cyc;
  int              m_k     [NBTN];
  int              m_since [NBTN];
  bit              m_ls    [NBTN];
  bit              m_tk;
  bit              m_valid = 1'b0;

  always @(posedge clk) begin
    m_raw = {sw_in, btn_in};
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0;
      m_long = '0; m_rep = '0; m_cyc = 0;
      for (int c = 0; c < NCH; c++) m_hist[c] = '0;
      for (int j = 0; j < NBTN; j++) begin m_k[j] = 0; m_since[j] = 0; m_ls[j] = 1'b0; end
    end else begin
      m_tk  = ((m_cyc % TDIV) == TDIV - 1);
      m_cyc = m_cyc + 1;
      m_smp = m_s2;
      m_s2  = m_s1;
      m_s1  = m_raw;
      m_rise = '0; m_fall = '0; m_long = '0; m_rep = '0;
      if (m_tk) begin
        for (int c = 0; c < NCH; c++) begin
          m_hist[c] = {m_hist[c][DEP-2:0], m_smp[c]};
          if (m_hist[c] == {DEP{~m_lvl[c]}}) begin
            if (m_lvl[c]) m_fall[c] = 1'b1; else m_rise[c] = 1'b1;
            m_lvl[c] = ~m_lvl[c];
          end
        end
      end
      for (int j = 0; j < NBTN; j++) begin
        if (m_rise[j]) begin
          m_k[j] = 0; m_ls[j] = 1'b0; m_rep[j] = repeat_en;
        end else if (m_fall[j]) begin
          m_k[j] = 0; m_ls[j] = 1'b0;
        end else if (m_tk && m_lvl[j]) begin
          if (!m_ls[j]) begin
            m_k[j] = m_k[j] + 1;
            if (m_k[j] == HOLD) begin
              m_long[j]  = 1'b1;
              m_rep[j]   = repeat_en;
              m_ls[j]    = 1'b1;
              m_since[j] = repeat_en ? 0 : REP;
            end
          end else if (repeat_en) begin
            m_since[j] = ((m_since[j] >= REP) ? 0 : m_since[j]) + 1;
            if (m_since[j] == REP) begin
              m_rep[j]   = 1'b1;
              m_since[j] = 0;
            end
          end else begin
            m_since[j] = (m_since[j] + 1 > REP) ? REP : m_since[j] + 1;
          end
        end
      end
    end
    m_valid = 1'b1;
  end

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;
  int cyc_no = 0;
  int press_cnt [NBTN];
  int rel_cnt   [NBTN];
  int long_cnt  [NBTN];
  int rep_cnt   [NBTN];
  int press_cyc [NBTN];
  int rel_cyc   [NBTN];
  int chg_cnt   [NSW];
  int chg_cyc   [NSW];
  int t_rel;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_no);
    end else begin
      n_pass++;
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NBTN; i++) begin
      press_cnt[i] = 0; rel_cnt[i] = 0; long_cnt[i] = 0; rep_cnt[i] = 0;
      press_cyc[i] = -1; rel_cyc[i] = -1;
    end
    for (int i = 0; i < NSW; i++) begin chg_cnt[i] = 0; chg_cyc[i] = -1; end
  endtask

  // Advance n clocks; at each falling edge compare everything with the model
  // and tally pulses for the directed checks.
  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      cyc_no++;
      if (m_valid) begin
        chk("btn_level",   btn_level,   m_lvl[NBTN-1:0]);
        chk("btn_press",   btn_press,   m_rise[NBTN-1:0]);
        chk("btn_release", btn_release, m_fall[NBTN-1:0]);
        chk("btn_long",    btn_long,    m_long);
        chk("btn_repeat",  btn_repeat,  m_rep);
        chk("sw_level",    sw_level,    m_lvl[NCH-1:NBTN]);
        chk("sw_change",   sw_change,   m_rise[NCH-1:NBTN] | m_fall[NCH-1:NBTN]);
      end
      for (int i = 0; i < NBTN; i++) begin
        if (btn_press[i])   begin press_cnt[i]++; press_cyc[i] = cyc_no; end
        if (btn_release[i]) begin rel_cnt[i]++;   rel_cyc[i]   = cyc_no; end
        if (btn_long[i])    long_cnt[i]++;
        if (btn_repeat[i])  rep_cnt[i]++;
      end
      for (int i = 0; i < NSW; i++)
        if (sw_change[i]) begin chg_cnt[i]++; chg_cyc[i] = cyc_no; end
    end
  endtask

  initial begin
    rst_n = 1'b0; repeat_en = 1'b0; btn_in = '1; sw_in = '0;
    clear_counts();

    // Reset with every button held: outputs stay 0, then one press each.
    run(5);
    chk("reset_btn_level", btn_level, 0);
    chk("reset_btn_press", btn_press, 0);
    rst_n = 1'b1;
    t_rel = cyc_no;
    run(30);
    chk("post_reset_level", btn_level, 5'h1f);
    for (int i = 0; i < NBTN; i++) chk("post_reset_press_cnt", press_cnt[i], 1);
    chk("press_latency", press_cyc[0] - t_rel, 12);
    btn_in = '0;
    run(24);

    // Glitch rejection on button 0.
    clear_counts();
    btn_in[0] = 1'b1; run(2 * TDIV);
    btn_in[0] = 1'b0; run(TDIV);
    chk("glitch_no_press", press_cnt[0], 0);
    btn_in[0] = 1'b1; run(5 * TDIV);
    chk("glitch_one_press", press_cnt[0], 1);
    btn_in[0] = 1'b0; run(24);

    // Short press/release on button 1: 7 ticks, below the long-press count.
    clear_counts();
    btn_in[1] = 1'b1; run(7 * TDIV);
    btn_in[1] = 1'b0; run(24);
    chk("pr_press_cnt", press_cnt[1], 1);
    chk("pr_rel_cnt", rel_cnt[1], 1);
    chk("pr_separation", rel_cyc[1] - press_cyc[1], 7 * TDIV);
    chk("pr_no_long", long_cnt[1], 0);

    // Long press with repeat on button 2: held through hold tick 21.
    clear_counts();
    repeat_en = 1'b1;
    btn_in[2] = 1'b1; run(22 * TDIV);
    btn_in[2] = 1'b0; run(24);
    chk("lp_repeat_cnt", rep_cnt[2], 6);
    chk("lp_long_cnt", long_cnt[2], 1);
    clear_counts();
    repeat_en = 1'b0;
    btn_in[2] = 1'b1; run(22 * TDIV);
    btn_in[2] = 1'b0; run(24);
    chk("lp_norep_repeat_cnt", rep_cnt[2], 0);
    chk("lp_norep_long_cnt", long_cnt[2], 1);

    // Simultaneous edges on buttons 0, 4 and switch 7.
    clear_counts();
    btn_in[0] = 1'b1; btn_in[4] = 1'b1; sw_in[7] = 1'b1;
    run(20);
    chk("sim_press0", press_cnt[0], 1);
    chk("sim_press4", press_cnt[4], 1);
    chk("sim_chg7", chg_cnt[7], 1);
    chk("sim_same_cycle_btn", press_cyc[4], press_cyc[0]);
    chk("sim_same_cycle_sw", chg_cyc[7], press_cyc[0]);
    chk("sim_sw_level7", sw_level[7], 1);
    btn_in = '0; sw_in = '0;
    run(24);

    // Reset in the middle of a hold on button 3.
    clear_counts();
    btn_in[3] = 1'b1; run(8 * TDIV);
    chk("mid_rst_no_long_yet", long_cnt[3], 0);
    rst_n = 1'b0; run(3);
    rst_n = 1'b1; run(14 * TDIV);
    chk("mid_rst_press_cnt", press_cnt[3], 2);
    chk("mid_rst_long_cnt", long_cnt[3], 1);
    btn_in[3] = 1'b0; run(24);
    chk("mid_rst_rel_cnt", rel_cnt[3], 1);

    // Random pins and repeat_en, one short reset in the middle.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NBTN; i++)
        if ($urandom_range(59) == 0) btn_in[i] = ~btn_in[i];
      for (int i = 0; i < NSW; i++)
        if ($urandom_range(29) == 0) sw_in[i] = ~sw_in[i];
      if ($urandom_range(399) == 0) repeat_en = ~repeat_en;
      rst_n = !(c >= 1500 && c < 1502);
      run(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
